board_scanner: RTL and testbench
================================

# board_scanner

Reader-side companion to the board RAM. On a start request it sweeps the macro address from 1 to 9 and samples the RAM's per-macro `state` output, which is registered. It then packs the nine macro results into one vector and resolves the global (meta-board) game result. The block sits between the board RAM and the game-control FSM, which uses `done`/`game_state` to end or continue the match.

## Interface
Parameters:
- `STATE_W`, default 2: width of a cell/macro result code.
- `ADDR_W`, default 4: width of the macro address bus.

Ports:
- `clk`  in  1: single clock, rising edge.
- `clear`  in  1: reset, asynchronous, active-high.
- `start`  in  1: scan request, sampled only in IDLE.
- `state_in`  in  2: the board RAM `state` output. It is valid one edge after the RAM samples `addr_macro`.
- `addr_macro`  out  4: macro address driven to the RAM.
- `busy`  out  1: high while a scan is in progress.
- `done`  out  1: one-cycle pulse when results are published.
- `macro_result`  out  18: published macro results. Bits [2k-1:2k-2] hold macro k, for k = 1..9.
- `game_state`  out  2: global result. 00 = ongoing, 01 = P1 won, 10 = P2 won, 11 = draw.
- `playable`  out  9: present only with the macro in Configuration. Bit k-1 is set when macro k is 00.

## Operation
- **Codes.** Result codes match the RAM: 00 ongoing, 01 P1, 10 P2, 11 draw.
- **FSM states:** IDLE, SCAN, DRAIN, RESOLVE.
- **IDLE → SCAN.** At an edge with `start`=1:
  - set `addr_macro`=1, issue index=1, capture index=0 (none);
  - assert `busy`.
- **SCAN.** `addr_macro` increments by 1 each edge up to 9. Capture index trails issue index by 2 edges.
  - At each edge with capture index k in 1..9, write `state_in` into shadow slot k.
- **SCAN → DRAIN.** Taken on the edge after `addr_macro` reaches 9. `addr_macro` holds at 9 until macro 9 is captured.
- **DRAIN → RESOLVE.** Taken on the edge that captures macro 9.
- **RESOLVE.** Copy shadow to `macro_result`, compute `game_state`, pulse `done`, drop `busy`, return to IDLE.
- **Line set.** Lines are the 8 tic-tac-toe lines over macros (1,2,3) (4,5,6) (7,8,9) (1,4,7) (2,5,8) (3,6,9) (1,5,9) (3,5,7).
- **Global resolution:**
  - P1 wins when any line has all three macros = 01. P2 wins likewise with 10. A macro draw (11) counts for nobody.
  - If both players have a line, the result is 11. This is an illegal board, flagged as draw.
  - With no winner, the result is 11 if all nine macros are ≠ 00, else 00.
- **Start while busy.** `start` is ignored while `busy`=1.
- **Start on the done cycle.** `start` asserted in the cycle `done` is high is accepted, because the FSM is then in IDLE.
- **Output stability.** `macro_result` and `game_state` change only at RESOLVE and hold between scans.
- **Writes during a scan.** RAM writes while `busy`=1 are the controller's fault. The scanner reports whatever it sampled and does not detect them.
- **Clear mid-scan.** Immediate return to IDLE; all outputs go to reset values.

## Timing
- **Reset values:** `addr_macro`=0, `busy`=0, `done`=0, `macro_result`=0, `game_state`=00, shadow=0, `playable`=9'h1FF.
- **Start to address 1.** With `start` sampled at edge E0, `addr_macro`=1 after E0.
- **Capture edges.** Macro k is captured at edge E(k+1): at E(k) the RAM registers `state` for address k; the scanner samples it one edge later.
- **Completion.** Macro 9 is captured at E10. RESOLVE occupies the cycle after E10. `done` is high for exactly the one cycle following E11, and `busy` is low in that cycle. Start to `done` is 12 cycles.
- **Address hold.** `addr_macro` holds its last value (9) while in IDLE after a scan.
- **Registration.** All outputs are registered; there are no combinational paths from `start` or `state_in` to any output.

## Configuration
- **`BOARD_SCANNER_PLAYABLE_EN` defined:**
  - The `playable` port exists. It is updated at RESOLVE to the per-macro "code == 00" mask, with reset value 9'h1FF.
  - Port `any_playable` (out, 1) is also added; it is the OR of `playable`.
- **Undefined:** neither port exists. All other behaviour is identical.

## Structure
- **Shared package `board_pkg`:**
  - result codes ONGOING/P1/P2/DRAW;
  - MACRO_FIRST=1 and MACRO_LAST=9;
  - scanner FSM state enum;
  - line table of 8 macro triplets.
- **Sub-module `board_line_check`.** Combinational; 9-bit occupancy mask in, `line_hit` out. It is instantiated twice, once on the P1 mask and once on the P2 mask.

## Test plan
- **Empty board:** all `state_in`=00, pulse `start` → `done` 12 cycles later, `macro_result`=0, `game_state`=00. With the macro, `playable`=9'h1FF.
- **P1 diagonal:** macros 1, 5, 9 = 01, others 00 → `game_state`=01, `macro_result`[1:0]=01, [9:8]=01, [17:16]=01.
- **Full board with no line:** macros 1..9 = 01,10,01,01,10,10,10,01,11 (every line mixed) → `game_state`=11.
- **Both lines present:** macros 1,2,3 = 01 and 7,8,9 = 10 → `game_state`=11.
- **Start handling:** `start` held through the scan → exactly one scan with no restart; `start` in the `done` cycle → second scan begins, second `done` 12 cycles later.
- **Clear mid-scan:** `clear` at cycle 5 → `busy`=0, `addr_macro`=0, `game_state`=00 immediately; no `done` pulse.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the board RAM reader: result codes, macro range,
// scanner FSM states and the tic-tac-toe line table over the nine macros.
package board_pkg;

  typedef enum logic [1:0] {
    ONGOING = 2'b00,
    P1      = 2'b01,
    P2      = 2'b10,
    DRAW    = 2'b11
  } result_e;

  localparam int MACRO_FIRST = 1;
  localparam int MACRO_LAST  = 9;
  localparam int NUM_MACROS  = MACRO_LAST - MACRO_FIRST + 1;
  localparam int NUM_LINES   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    RESOLVE
  } scan_state_e;

  // Each triplet holds zero-based slot indices, i.e. macro k lives at slot k-1.
  localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/board_line_check.sv
// Combinational three-in-a-row detector: flags whether any of the eight
// macro lines is fully covered by the given per-macro occupancy mask.
module board_line_check
  import board_pkg::*;
(
  input  logic [NUM_MACROS-1:0] mask_i,
  output logic                  line_hit
);

  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      line_hit = line_hit | (mask_i[LINE_TABLE[i][0]] &
                             mask_i[LINE_TABLE[i][1]] &
                             mask_i[LINE_TABLE[i][2]]);
    end
  end

endmodule

// File: rtl/board_scanner.sv
// Sweeps board RAM macros 1..9, packs the sampled results and resolves the
// meta-board outcome. Define BOARD_SCANNER_PLAYABLE_EN to add playable/any_playable.
module board_scanner
  import board_pkg::*;
#(
  parameter int STATE_W = 2,
  parameter int ADDR_W  = 4
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          start,
  input  logic [STATE_W-1:0]            state_in,
  output logic [ADDR_W-1:0]             addr_macro,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_MACROS*STATE_W-1:0] macro_result,
  output logic [STATE_W-1:0]            game_state
`ifdef BOARD_SCANNER_PLAYABLE_EN
  , output logic [NUM_MACROS-1:0]       playable
  , output logic                        any_playable
`endif
);

  scan_state_e                   state_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [ADDR_W-1:0]             capIdx_q;
  logic                          busy_q;
  logic                          done_q;
  logic [NUM_MACROS*STATE_W-1:0] shadow_q;
  logic [NUM_MACROS*STATE_W-1:0] macroResult_q;
  logic [STATE_W-1:0]            gameState_q;
  logic [STATE_W-1:0]            gameState_d;
  logic [NUM_MACROS-1:0]         p1Mask;
  logic [NUM_MACROS-1:0]         p2Mask;
  logic [NUM_MACROS-1:0]         filledMask;
  logic                          p1Line;
  logic                          p2Line;

  always_comb begin
    p1Mask     = '0;
    p2Mask     = '0;
    filledMask = '0;
    for (int k = 0; k < NUM_MACROS; k++) begin
      p1Mask[k]     = (shadow_q[k*STATE_W +: STATE_W] == STATE_W'(P1));
      p2Mask[k]     = (shadow_q[k*STATE_W +: STATE_W] == STATE_W'(P2));
      filledMask[k] = (shadow_q[k*STATE_W +: STATE_W] != STATE_W'(ONGOING));
    end
  end

  board_line_check u_p1_lines (
    .mask_i   (p1Mask),
    .line_hit (p1Line)
  );

  board_line_check u_p2_lines (
    .mask_i   (p2Mask),
    .line_hit (p2Line)
  );

  // Two simultaneous winners cannot arise in legal play, so it is reported as a draw.
  always_comb begin
    gameState_d = STATE_W'(ONGOING);
    if (p1Line && p2Line) begin
      gameState_d = STATE_W'(DRAW);
    end else if (p1Line) begin
      gameState_d = STATE_W'(P1);
    end else if (p2Line) begin
      gameState_d = STATE_W'(P2);
    end else if (&filledMask) begin
      gameState_d = STATE_W'(DRAW);
    end
  end

  // The RAM output lags its address by one edge, so capture trails issue by two.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      capIdx_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      shadow_q      <= '0;
      macroResult_q <= '0;
      gameState_q   <= STATE_W'(ONGOING);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SCAN;
            addr_q   <= ADDR_W'(MACRO_FIRST);
            capIdx_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SCAN: begin
          capIdx_q <= addr_q;
          if (addr_q == ADDR_W'(MACRO_LAST)) begin
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (capIdx_q == ADDR_W'(MACRO_LAST)) begin
            state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          macroResult_q <= shadow_q;
          gameState_q   <= gameState_d;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (state_q == SCAN || state_q == DRAIN) begin
        for (int k = 0; k < NUM_MACROS; k++) begin
          if (capIdx_q == ADDR_W'(k + MACRO_FIRST)) begin
            shadow_q[k*STATE_W +: STATE_W] <= state_in;
          end
        end
      end
    end
  end

  assign addr_macro   = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign macro_result = macroResult_q;
  assign game_state   = gameState_q;

`ifdef BOARD_SCANNER_PLAYABLE_EN
  logic [NUM_MACROS-1:0] playable_q;
  logic                  anyPlayable_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      playable_q    <= '1;
      anyPlayable_q <= 1'b1;
    end else if (state_q == RESOLVE) begin
      playable_q    <= ~filledMask;
      anyPlayable_q <= ~(&filledMask);
    end
  end

  assign playable     = playable_q;
  assign any_playable = anyPlayable_q;
`else
  // Without the playable outputs the filled mask only feeds the draw check.
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a registered RAM model serves hand-picked
// boards and each scan is checked against hand-computed results and timing.
module tb_board_scanner;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  stateIn;
  logic [3:0]  addrMacro;
  logic        busy;
  logic        done;
  logic [17:0] macroResult;
  logic [1:0]  gameState;
`ifdef BOARD_SCANNER_PLAYABLE_EN
  logic [8:0]  playable;
  logic        anyPlayable;
`endif

  logic [1:0]  board [0:15];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  board_scanner dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .state_in     (stateIn),
    .addr_macro   (addrMacro),
    .busy         (busy),
    .done         (done),
    .macro_result (macroResult),
    .game_state   (gameState)
`ifdef BOARD_SCANNER_PLAYABLE_EN
    , .playable     (playable)
    , .any_playable (anyPlayable)
`endif
  );

  // Board RAM model: registered read of the addressed macro.
  always @(posedge clk) begin
    stateIn <= board[addrMacro];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic loadBoard(input logic [17:0] packedBoard);
    for (int k = 1; k <= 9; k++) begin
      board[k] = packedBoard[2*k-2 +: 2];
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, cyc, 11);
  endtask

  task automatic checkScan(input string tag, input logic [17:0] expResult, input logic [1:0] expGame,
                           input logic [8:0] expPlayable);
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_result"}, macroResult, expResult);
    checkOutput({tag, "_game"}, gameState, expGame);
`ifdef BOARD_SCANNER_PLAYABLE_EN
    checkOutput({tag, "_playable"}, playable, expPlayable);
    checkOutput({tag, "_any"}, anyPlayable, (expPlayable != 9'h0));
`else
    if (expPlayable === 9'bx) $display("[TB] unreachable");
`endif
  endtask

  initial begin
    int doneCount;
    clear = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 16; k++) board[k] = 2'b00;
    repeat (2) @(negedge clk);

    checkOutput("reset_addr", addrMacro, 4'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_result", macroResult, 18'h0);
    checkOutput("reset_game", gameState, 2'b00);
`ifdef BOARD_SCANNER_PLAYABLE_EN
    checkOutput("reset_playable", playable, 9'h1FF);
    checkOutput("reset_any", anyPlayable, 1'b1);
`endif
    clear = 1'b0;
    @(negedge clk);

    // Empty board.
    loadBoard(18'h0);
    applyStimulus();
    checkOutput("empty_start_addr", addrMacro, 4'd1);
    checkOutput("empty_start_busy", busy, 1'b1);
    waitDone("empty_latency");
    checkScan("empty", 18'h0, 2'b00, 9'h1FF);
    @(negedge clk);
    checkOutput("done_width", done, 1'b0);
    checkOutput("addr_hold", addrMacro, 4'd9);

    // P1 diagonal 1-5-9.
    loadBoard(18'h10101);
    applyStimulus();
    waitDone("p1diag_latency");
    checkScan("p1diag", 18'h10101, 2'b01, 9'h0EE);
    @(negedge clk);

    // P2 column 2-5-8 with a stray P1 macro.
    loadBoard(18'h08209);
    applyStimulus();
    waitDone("p2col_latency");
    checkScan("p2col", 18'h08209, 2'b10, 9'h16C);
    @(negedge clk);
    checkOutput("p2col_hold_result", macroResult, 18'h08209);
    checkOutput("p2col_hold_game", gameState, 2'b10);

    // Full board, every line mixed.
    loadBoard(18'h36A59);
    applyStimulus();
    waitDone("full_latency");
    checkScan("full", 18'h36A59, 2'b11, 9'h000);
    @(negedge clk);

    // Same pattern with macro 9 still open: no winner, not full.
    loadBoard(18'h06A59);
    applyStimulus();
    waitDone("open9_latency");
    checkScan("open9", 18'h06A59, 2'b00, 9'h100);

    // Start raised in the done cycle: both players own a line.
    loadBoard(18'h2A015);
    applyStimulus();
    checkOutput("chain_start_busy", busy, 1'b1);
    checkOutput("chain_start_addr", addrMacro, 4'd1);
    waitDone("chain_latency");
    checkScan("both", 18'h2A015, 2'b11, 9'h038);
    @(negedge clk);

    // Start held through most of the scan yields a single scan.
    loadBoard(18'h10101);
    start = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("held_busy", busy, 1'b1);
    start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("held_done_count", doneCount, 1);
    checkOutput("held_busy_end", busy, 1'b0);
    checkOutput("held_game", gameState, 2'b01);

    // Clear in the middle of a scan.
    loadBoard(18'h36A59);
    applyStimulus();
    repeat (4) @(negedge clk);
    clear = 1'b1;
    #1;
    checkOutput("clear_busy", busy, 1'b0);
    checkOutput("clear_addr", addrMacro, 4'd0);
    checkOutput("clear_game", gameState, 2'b00);
    checkOutput("clear_result", macroResult, 18'h0);
    @(negedge clk);
    clear = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("clear_no_done", doneCount, 0);
    checkOutput("clear_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
